// File: rtl/bt_blink_ctrl_if.sv
// -----------------------------------------------------------------------------
// bt_blink_ctrl_if
//   Signal bundle between the Bluetooth blink controller and its environment.
//   The slave modport is the controller itself; the master modport is the
//   side that owns the UART line and observes the LEDs and status pulses.
//
//   rx         UART receive line, idle high (into the controller)
//   led        LED drive per channel, 1 = on
//   busy       channel is running a blink sequence
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse on a bad stop bit
//   cmd_err    one-cycle pulse on an invalid channel byte or a count timeout
// -----------------------------------------------------------------------------
interface bt_blink_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic              rx;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] busy;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              cmd_err;

  modport master (
    output rx,
    input  led, busy, rx_data, rx_valid, frame_err, cmd_err
  );

  modport slave (
    input  rx,
    output led, busy, rx_data, rx_valid, frame_err, cmd_err
  );
endinterface

// File: rtl/bt_blink_ctrl.sv
// -----------------------------------------------------------------------------
// bt_blink_ctrl
//   Bluetooth-controlled blink controller: an 8N1 UART receiver, a two-byte
//   command parser (channel byte, then count byte) and NUM_CH blink engines.
//   A count N > 0 (re)starts N on/off cycles on the target channel; N = 0
//   stops it. Channel byte 0xFF addresses every channel at once.
//
//   WF_CLK     system clock, rising edge
//   WF_BUTTON  synchronous active-low reset
//   bus        bt_blink_ctrl_if.slave: rx in; led, busy, rx_data, rx_valid,
//              frame_err, cmd_err out
// -----------------------------------------------------------------------------
module bt_blink_ctrl #(
  parameter int CLK_HZ      = 16000000,
  parameter int BAUD        = 9600,
  parameter int NUM_CH      = 4,
  parameter int HALF_CYC    = 8000000,
  parameter int TIMEOUT_CYC = 16000000
) (
  input  logic            WF_CLK,
  input  logic            WF_BUTTON,
  bt_blink_ctrl_if.slave  bus
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_BIT = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);
  localparam int GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int TMR_W    = $clog2(HALF_CYC + 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic       {P_WAIT_CH, P_WAIT_CNT}            parse_state_e;
  typedef enum logic [1:0] {E_IDLE, E_ON, E_OFF}              eng_state_e;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  logic             r_rx_meta;
  logic             r_rx_sync;
  uart_state_e      r_u_state,   w_u_state_n;
  logic [CNT_W-1:0] r_bit_cnt,   w_bit_cnt_n;
  logic [2:0]       r_bit_idx,   w_bit_idx_n;
  logic [7:0]       r_shift,     w_shift_n;
  logic [7:0]       r_rx_data,   w_rx_data_n;
  logic             r_rx_valid,  w_rx_valid_n;
  logic             r_frame_err, w_frame_err_n;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge WF_CLK) begin
    if (!WF_BUTTON) begin
      r_rx_meta   <= 1'b0;
      r_rx_sync   <= 1'b0;
      r_u_state   <= U_IDLE;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Two flops before any decision: rx is asynchronous to WF_CLK.
      r_rx_meta   <= bus.rx;
      r_rx_sync   <= r_rx_meta;
      r_u_state   <= w_u_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_bit_idx   <= w_bit_idx_n;
      r_shift     <= w_shift_n;
      r_rx_data   <= w_rx_data_n;
      r_rx_valid  <= w_rx_valid_n;
      r_frame_err <= w_frame_err_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_u_state_n   = r_u_state;
    w_bit_cnt_n   = r_bit_cnt + CNT_W'(1);
    w_bit_idx_n   = r_bit_idx;
    w_shift_n     = r_shift;
    w_rx_data_n   = r_rx_data;
    w_rx_valid_n  = 1'b0;
    w_frame_err_n = 1'b0;

    case (r_u_state)
      U_IDLE: begin
        w_bit_cnt_n = '0;
        if (!r_rx_sync) w_u_state_n = U_START;
      end
      U_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (r_bit_cnt == CNT_W'(HALF_BIT - 1)) begin
          w_bit_cnt_n = '0;
          w_bit_idx_n = '0;
          w_u_state_n = r_rx_sync ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (r_bit_cnt == CNT_W'(BIT_CYC - 1)) begin
          w_bit_cnt_n = '0;
          w_shift_n   = {r_rx_sync, r_shift[7:1]};  // LSB arrives first
          w_bit_idx_n = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_u_state_n = U_STOP;
        end
      end
      U_STOP: begin
        if (r_bit_cnt == CNT_W'(BIT_CYC - 1)) begin
          w_bit_cnt_n = '0;
          w_u_state_n = U_IDLE;
          if (r_rx_sync) begin
            w_rx_data_n  = r_shift;
            w_rx_valid_n = 1'b1;
          end else begin
            w_frame_err_n = 1'b1;
          end
        end
      end
      default: w_u_state_n = U_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command parser
  // ---------------------------------------------------------------------------
  parse_state_e     r_p_state, w_p_state_n;
  logic [7:0]       r_target,  w_target_n;
  logic [GAP_W-1:0] r_gap,     w_gap_n;
  logic             r_cmd_err, w_cmd_err_n;
  logic             w_ch_ok;
  logic             w_cmd_fire;

  assign w_ch_ok    = (r_rx_data < 8'(NUM_CH)) || (r_rx_data == 8'hFF);
  // The count byte is consumed in the cycle its rx_valid is high, so the
  // engines load at the following edge.
  assign w_cmd_fire = (r_p_state == P_WAIT_CNT) && r_rx_valid;

  always_ff @(posedge WF_CLK) begin
    if (!WF_BUTTON) begin
      r_p_state <= P_WAIT_CH;
      r_target  <= '0;
      r_gap     <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_p_state <= w_p_state_n;
      r_target  <= w_target_n;
      r_gap     <= w_gap_n;
      r_cmd_err <= w_cmd_err_n;
    end
  end

  always_comb begin
    w_p_state_n = r_p_state;
    w_target_n  = r_target;
    w_gap_n     = '0;
    w_cmd_err_n = 1'b0;

    case (r_p_state)
      P_WAIT_CH: begin
        if (r_rx_valid) begin
          if (w_ch_ok) begin
            w_target_n  = r_rx_data;
            w_p_state_n = P_WAIT_CNT;
          end else begin
            w_cmd_err_n = 1'b1;
          end
        end
      end
      P_WAIT_CNT: begin
        w_gap_n = r_gap + GAP_W'(1);
        // A byte arriving in the timeout cycle takes priority.
        if (r_rx_valid) begin
          w_p_state_n = P_WAIT_CH;
        end else if (r_gap == GAP_W'(TIMEOUT_CYC - 1)) begin
          w_cmd_err_n = 1'b1;
          w_p_state_n = P_WAIT_CH;
        end
      end
      default: w_p_state_n = P_WAIT_CH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Blink engines
  // ---------------------------------------------------------------------------
  eng_state_e       r_e_state [NUM_CH];
  eng_state_e       w_e_state_n [NUM_CH];
  logic [7:0]       r_rem [NUM_CH];
  logic [7:0]       w_rem_n [NUM_CH];
  logic [TMR_W-1:0] r_tmr [NUM_CH];
  logic [TMR_W-1:0] w_tmr_n [NUM_CH];
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_led;
  logic [NUM_CH-1:0] w_busy;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i] = w_cmd_fire && ((r_target == 8'hFF) || (r_target == 8'(i)));
    end
  end

  // NOTE: the per-channel arrays are ordinary registers (one set per engine,
  // not a RAM), so they take part in the reset like any other state.
  always_ff @(posedge WF_CLK) begin
    if (!WF_BUTTON) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_e_state[i] <= E_IDLE;
        r_rem[i]     <= '0;
        r_tmr[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_e_state[i] <= w_e_state_n[i];
        r_rem[i]     <= w_rem_n[i];
        r_tmr[i]     <= w_tmr_n[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_e_state_n[i] = r_e_state[i];
      w_rem_n[i]     = r_rem[i];
      w_tmr_n[i]     = '0;

      case (r_e_state[i])
        E_IDLE: ;
        E_ON: begin
          if (r_tmr[i] == TMR_W'(HALF_CYC - 1)) w_e_state_n[i] = E_OFF;
          else                                  w_tmr_n[i]     = r_tmr[i] + TMR_W'(1);
        end
        E_OFF: begin
          if (r_tmr[i] == TMR_W'(HALF_CYC - 1)) begin
            // One full on/off cycle completed.
            w_rem_n[i]     = r_rem[i] - 8'd1;
            w_e_state_n[i] = (r_rem[i] == 8'd1) ? E_IDLE : E_ON;
          end else begin
            w_tmr_n[i] = r_tmr[i] + TMR_W'(1);
          end
        end
        default: w_e_state_n[i] = E_IDLE;
      endcase

      // A new command overrides whatever the engine was doing (restart/stop).
      if (w_hit[i]) begin
        w_tmr_n[i] = '0;
        if (r_rx_data != 8'd0) begin
          w_e_state_n[i] = E_ON;
          w_rem_n[i]     = r_rx_data;
        end else begin
          w_e_state_n[i] = E_IDLE;
          w_rem_n[i]     = '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_led[i]  = (r_e_state[i] == E_ON);
      w_busy[i] = (r_e_state[i] != E_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.led       = w_led;
  assign bus.busy      = w_busy;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.cmd_err   = r_cmd_err;

endmodule

// File: doc/bt_blink_ctrl.md
# bt_blink_ctrl

Parametrised Bluetooth-controlled blink controller for the robot board. It integrates an 8N1 UART receiver, a two-byte command parser and NUM_CH independent blink engines. The host can start, restart or stop a blink sequence of N on/off cycles on any LED channel, or on all channels at once. It sits between the Bluetooth Rx pin (mapped onto an IR sensor pin) and the board LEDs, and supersedes the single-channel sleep/blink controller.

## Interface
Parameters:
- CLK_HZ, 16000000, system clock frequency in Hz
- BAUD, 9600, UART bit rate; BIT_CYC = CLK_HZ/BAUD (integer division, must be ≥ 8)
- NUM_CH, 4, number of LED channels, 1..8
- HALF_CYC, 8000000, cycles per LED on-phase and per off-phase
- TIMEOUT_CYC, 16000000, maximum gap between channel byte and count byte

Ports:
- WF_CLK  input  1  system clock; all logic is on the rising edge
- WF_BUTTON  input  1  reset, synchronous, active-low
- rx  input  1  UART receive line, idle high, asynchronous to WF_CLK
- led  output  NUM_CH  LED drive, 1 = on
- busy  output  NUM_CH  channel is running a sequence (state ON or OFF)
- rx_data  output  8  last correctly framed byte
- rx_valid  output  1  one-cycle pulse when rx_data updates
- frame_err  output  1  one-cycle pulse when a byte has a bad stop bit
- cmd_err  output  1  one-cycle pulse on an invalid channel byte or a timeout

## Operation
- Reset (WF_BUTTON low at a clock edge) forces all outputs and registers to 0, all engines to IDLE and the parser to WAIT_CH. Reset mid-frame or mid-sequence aborts it.
- The UART receiver passes rx through a 2-flop synchronizer and has states IDLE, START, DATA, STOP.
  - IDLE → START on the synchronized line going low.
  - In START, the line is sampled at BIT_CYC/2. If high (glitch), return to IDLE. If low, go to DATA.
  - In DATA, 8 bits are sampled, LSB first, every BIT_CYC cycles.
  - In STOP, one sample is taken after a further BIT_CYC. A 1 updates rx_data and pulses rx_valid. A 0 pulses frame_err, discards the byte and leaves rx_data unchanged. Either way the receiver returns to IDLE.
- The parser has states WAIT_CH and WAIT_CNT.
  - In WAIT_CH, a byte < NUM_CH or equal to 0xFF latches the target and moves to WAIT_CNT. 0xFF means all channels. Any other value pulses cmd_err and the parser stays in WAIT_CH.
  - In WAIT_CNT, the next byte is the count N. The parser issues the command to the target channel(s) and returns to WAIT_CH.
  - In WAIT_CNT, a gap counter reaching TIMEOUT_CYC without a byte pulses cmd_err and returns the parser to WAIT_CH.
  - A framing error does not advance the parser.
- Each blink engine has states IDLE, ON and OFF and holds an 8-bit remaining count plus a phase timer.
  - A command with N > 0 loads remaining = N, clears the timer and enters ON. This applies even when the channel is busy (restart).
  - A command with N = 0 forces IDLE.
  - ON lasts HALF_CYC cycles, then the engine enters OFF. OFF lasts HALF_CYC cycles. At the end of OFF, remaining is decremented; if it reaches 0 the engine enters IDLE, otherwise ON.
  - led = (state == ON). busy = (state != IDLE).
- A 0xFF command applies identically and in the same cycle to every channel.

## Timing
- Let t0 be the cycle in which the synchronized line is first seen low. That is 2–3 cycles after the rx falling edge.
- The start check is at t0+BIT_CYC/2. Data bit k (k = 0..7) is sampled at t0+BIT_CYC/2+(k+1)·BIT_CYC. The stop bit is sampled at t0+BIT_CYC/2+9·BIT_CYC.
- rx_valid and frame_err are asserted in the cycle after the stop sample. rx_data is valid in that same cycle.
- After a stop sample the receiver is in IDLE and can detect a new start bit in the very next cycle; back-to-back frames are supported.
- A command takes effect in the engine one cycle after the count byte's rx_valid. led goes high, or low for N = 0, in that same cycle.
- A sequence of N blinks lasts exactly 2·N·HALF_CYC cycles from led rising to busy falling.
- The parser's timeout counter starts in the cycle after the channel byte's rx_valid.
- If the timeout and an rx_valid occur in the same cycle, the byte wins and no cmd_err is raised.

## Test plan
Use CLK_HZ=1600, BAUD=100 (BIT_CYC=16), NUM_CH=4, HALF_CYC=8, TIMEOUT_CYC=400.
- Send 0xA5 with a correct stop bit → rx_data=0xA5, a single rx_valid pulse in the cycle after the stop sample, frame_err stays 0.
- Send 0x02 then 0x03 → only led[2] toggles: 3 on-phases of 8 cycles; busy[2] high for exactly 48 cycles; then led[2]=0 and busy[2]=0.
- Send 0xFF then 0x01 → led[3:0] rise in the same cycle, each stays on 8 cycles, all busy bits drop together after 16 cycles.
- Start 0x01,0x05; during the second blink send 0x01,0x00 → led[1]=0 and busy[1]=0 one cycle after the second rx_valid. Resend 0x01,0x02 → restart from a full count of 2.
- Send 0x07 → cmd_err pulse, parser stays in WAIT_CH. Send 0x00 then wait 400 cycles → cmd_err pulse; a following 0x03 is treated as a channel byte.
- Send a frame with stop bit 0 → frame_err pulse, no rx_valid, rx_data unchanged. Assert WF_BUTTON low mid-sequence → all outputs 0 on the next edge.
